// File: rtl/axis_split_pkg.sv
// Shared types and helpers for the AXI4-Stream metadata splitter.
//   state_t  : packet parser state (SOP, BODY, DROP)
//   meta_t   : metadata word layout {trunc, beats, len, hdr}, MSB first,
//              sized for the default 32-byte header capture
//   popcount : number of set bits in a TKEEP vector (zero-extended to MAX_KEEP_W)
package axis_split_pkg;

   localparam int PKG_HDR_BYTES = 32;
   localparam int MAX_KEEP_W    = 128;
   localparam int BEATS_W       = 12;
   localparam int LEN_W         = 16;

   typedef enum logic [1:0] {
      SOP  = 2'd0,
      BODY = 2'd1,
      DROP = 2'd2
   } state_t;

   typedef struct packed {
      logic                       trunc;
      logic [BEATS_W-1:0]         beats;
      logic [LEN_W-1:0]           len;
      logic [PKG_HDR_BYTES*8-1:0] hdr;
   } meta_t;

   function automatic logic [LEN_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
      logic [LEN_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_KEEP_W; i++) begin
         cnt = cnt + LEN_W'(keep[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read ports.
//   clk, rst      : clock, synchronous active-low reset (empties the FIFO)
//   wr_en/wr_data : push (ignored while full)
//   rd_en         : pop (ignored while empty)
//   rd_data       : entry at the head
//   rd_data_nxt   : entry behind the head (valid only when has_two)
//   has_two       : at least two entries stored
//   full, empty   : occupancy flags from the extra pointer MSB
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] rd_data_nxt,
   output logic             has_two,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      count;
   logic [AW-1:0]    rd_idx;
   logic [AW-1:0]    rd_idx_nxt;

   assign rd_idx     = rd_ptr_reg[AW-1:0];
   assign rd_idx_nxt = rd_idx + AW'(1);
   assign count      = wr_ptr_reg - rd_ptr_reg;
   assign empty      = (wr_ptr_reg == rd_ptr_reg);
   assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign has_two    = (count > (AW+1)'(1));
   assign rd_data     = mem[rd_idx];
   assign rd_data_nxt = mem[rd_idx_nxt];

   // Storage carries no reset so it can map onto RAM primitives.
   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_en && !full) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         end
         if (rd_en && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/axis_meta_splitter.sv
// Splits one AXI4-Stream packet stream into a data stream (every kept beat,
// through a delay FIFO) and a one-beat-per-packet metadata stream carrying
// {trunc, beats, len, hdr}. Packets longer than MAX_BEATS are cut: the last
// kept beat gets TLAST forced and the remainder is discarded.
//   clk, rst                      : clock, synchronous active-low reset
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast : ingress stream
//   m_data_*                      : data egress (registered, held until ready)
//   m_meta_*                      : metadata egress (registered, held until ready)
module axis_meta_splitter
   import axis_split_pkg::*;
#(
   parameter int DATA_W     = 512,
   parameter int DATA_DEPTH = 16,
   parameter int META_DEPTH = 4,
   parameter int HDR_BYTES  = 32,
   parameter int MAX_BEATS  = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [DATA_W-1:0]          s_tdata,
   input  logic [DATA_W/8-1:0]        s_tkeep,
   input  logic                       s_tlast,
   output logic                       m_data_tvalid,
   input  logic                       m_data_tready,
   output logic [DATA_W-1:0]          m_data_tdata,
   output logic [DATA_W/8-1:0]        m_data_tkeep,
   output logic                       m_data_tlast,
   output logic                       m_meta_tvalid,
   input  logic                       m_meta_tready,
   output logic [HDR_BYTES*8+28:0]    m_meta_tdata,
   output logic                       m_meta_tlast
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int HDR_W  = HDR_BYTES * 8;
   localparam int META_W = HDR_W + LEN_W + BEATS_W + 1;
   localparam int DQ_W   = DATA_W + KEEP_W + 1;

   state_t             state_reg;
   logic [BEATS_W-1:0] beats_reg;
   logic [LEN_W-1:0]   len_reg;
   logic [HDR_W-1:0]   hdr_reg;

   logic               accept;
   logic [LEN_W-1:0]   keep_cnt;
   logic [LEN_W:0]     len_sum;
   logic [LEN_W-1:0]   len_new;
   logic [BEATS_W-1:0] beats_new;
   logic [HDR_W-1:0]   hdr_new;
   logic               hit_max;
   logic               pkt_end;
   logic               d_wr, m_wr, d_pop, m_pop;
   logic               d_full, d_empty, d_has_two;
   logic               m_full, m_empty, m_has_two;
   logic [DQ_W-1:0]    d_wr_data, d_rd_data, d_rd_nxt, d_out_reg;
   logic [META_W-1:0]  m_wr_data, m_rd_data, m_rd_nxt, m_out_reg;
   logic               d_valid_reg, m_valid_reg;

   assign s_tready = rst && !d_full && !m_full;
   assign accept   = s_tvalid && s_tready;

   // Per-beat values as they will stand once this beat is counted; the meta
   // word is built from these so it lands in the same cycle as the last beat.
   assign keep_cnt  = popcount(MAX_KEEP_W'(s_tkeep));
   assign len_sum   = (state_reg == SOP) ? {1'b0, keep_cnt}
                                         : {1'b0, len_reg} + {1'b0, keep_cnt};
   assign len_new   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
   assign beats_new = (state_reg == SOP) ? BEATS_W'(1) : beats_reg + BEATS_W'(1);
   assign hdr_new   = (state_reg == SOP) ? s_tdata[HDR_W-1:0] : hdr_reg;
   assign hit_max   = !s_tlast && (beats_new == BEATS_W'(MAX_BEATS));
   assign pkt_end   = s_tlast || hit_max;

   assign d_wr      = accept && (state_reg != DROP);
   assign m_wr      = d_wr && pkt_end;
   assign d_wr_data = {pkt_end, s_tkeep, s_tdata};
   assign m_wr_data = {hit_max, beats_new, len_new, hdr_new};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= SOP;
         beats_reg <= '0;
         len_reg   <= '0;
         hdr_reg   <= '0;
      end else if (accept) begin
         unique case (state_reg)
            SOP, BODY: begin
               beats_reg <= beats_new;
               len_reg   <= len_new;
               hdr_reg   <= hdr_new;
               if (s_tlast)      state_reg <= SOP;
               else if (hit_max) state_reg <= DROP;
               else              state_reg <= BODY;
            end
            DROP: begin
               if (s_tlast) state_reg <= SOP;
            end
            default: state_reg <= SOP;
         endcase
      end
   end

   sync_fifo #(.WIDTH(DQ_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (d_wr),
      .wr_data     (d_wr_data),
      .rd_en       (d_pop),
      .rd_data     (d_rd_data),
      .rd_data_nxt (d_rd_nxt),
      .has_two     (d_has_two),
      .full        (d_full),
      .empty       (d_empty)
   );

   sync_fifo #(.WIDTH(META_W), .DEPTH(META_DEPTH)) u_meta_fifo (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (m_wr),
      .wr_data     (m_wr_data),
      .rd_en       (m_pop),
      .rd_data     (m_rd_data),
      .rd_data_nxt (m_rd_nxt),
      .has_two     (m_has_two),
      .full        (m_full),
      .empty       (m_empty)
   );

   // Output registers mirror the FIFO head without popping it, so the FIFO
   // depth is the whole buffering capacity. The head is popped on transfer and
   // the entry behind it is loaded in the same cycle to keep one beat/cycle.
   assign d_pop = d_valid_reg && m_data_tready;
   assign m_pop = m_valid_reg && m_meta_tready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         d_valid_reg <= 1'b0;
         d_out_reg   <= '0;
      end else if (!d_valid_reg) begin
         if (!d_empty) begin
            d_out_reg   <= d_rd_data;
            d_valid_reg <= 1'b1;
         end
      end else if (m_data_tready) begin
         if (d_has_two) d_out_reg   <= d_rd_nxt;
         else           d_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         m_valid_reg <= 1'b0;
         m_out_reg   <= '0;
      end else if (!m_valid_reg) begin
         if (!m_empty) begin
            m_out_reg   <= m_rd_data;
            m_valid_reg <= 1'b1;
         end
      end else if (m_meta_tready) begin
         if (m_has_two) m_out_reg   <= m_rd_nxt;
         else           m_valid_reg <= 1'b0;
      end
   end

   assign m_data_tvalid = d_valid_reg;
   assign {m_data_tlast, m_data_tkeep, m_data_tdata} = d_out_reg;
   assign m_meta_tvalid = m_valid_reg;
   assign m_meta_tdata  = m_out_reg;
   assign m_meta_tlast  = m_valid_reg;

endmodule

// File: tb/tb_axis_meta_splitter.sv
// Self-checking bench for axis_meta_splitter with default parameters.
module tb_axis_meta_splitter;
   import axis_split_pkg::*;

   localparam int DATA_W    = 512;
   localparam int KEEP_W    = 64;
   localparam int HDR_BYTES = 32;
   localparam int MAX_BEATS = 24;
   localparam int META_W    = HDR_BYTES * 8 + 29;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] k;
      logic              l;
   } beat_t;

   logic              clk;
   logic              rst;
   logic              s_tvalid, s_tready, s_tlast;
   logic [DATA_W-1:0] s_tdata;
   logic [KEEP_W-1:0] s_tkeep;
   logic              m_data_tvalid, m_data_tready, m_data_tlast;
   logic [DATA_W-1:0] m_data_tdata;
   logic [KEEP_W-1:0] m_data_tkeep;
   logic              m_meta_tvalid, m_meta_tready, m_meta_tlast;
   logic [META_W-1:0] m_meta_tdata;

   int errors = 0;
   int checks = 0;
   int tmo = 0;
   int hold_viol = 0;
   int d_rdy_mode = 0;   // 0 always ready, 1 never ready, 2 random
   int m_rdy_mode = 0;
   int unsigned cyc = 0;
   int unsigned last_acc = 0;

   beat_t             pkt_q[$];
   beat_t             exp_data[$];
   beat_t             got_data[$];
   logic [META_W-1:0] exp_meta[$];
   logic [META_W-1:0] got_meta[$];
   int unsigned       got_data_cyc[$];
   int unsigned       got_meta_cyc[$];

   logic              d_stall, m_stall;
   logic [DATA_W+KEEP_W:0] d_hold;
   logic [META_W-1:0]      m_hold;

   axis_meta_splitter dut (
      .clk           (clk),
      .rst           (rst),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tdata       (s_tdata),
      .s_tkeep       (s_tkeep),
      .s_tlast       (s_tlast),
      .m_data_tvalid (m_data_tvalid),
      .m_data_tready (m_data_tready),
      .m_data_tdata  (m_data_tdata),
      .m_data_tkeep  (m_data_tkeep),
      .m_data_tlast  (m_data_tlast),
      .m_meta_tvalid (m_meta_tvalid),
      .m_meta_tready (m_meta_tready),
      .m_meta_tdata  (m_meta_tdata),
      .m_meta_tlast  (m_meta_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      m_data_tready = (d_rdy_mode == 0) || (d_rdy_mode == 2 && $urandom_range(0, 99) < 70);
      m_meta_tready = (m_rdy_mode == 0) || (m_rdy_mode == 2 && $urandom_range(0, 99) < 70);
   end

   // Egress collector: records transfers with their edge index and counts
   // any stalled output that changed or dropped before being taken.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         d_stall <= 1'b0;
         m_stall <= 1'b0;
      end else begin
         if ((d_stall && (!m_data_tvalid || {m_data_tlast, m_data_tkeep, m_data_tdata} != d_hold)) ||
             (m_stall && (!m_meta_tvalid || m_meta_tdata != m_hold)))
            hold_viol <= hold_viol + 1;
         if (m_data_tvalid && m_data_tready) begin
            got_data.push_back('{d: m_data_tdata, k: m_data_tkeep, l: m_data_tlast});
            got_data_cyc.push_back(cyc);
         end
         if (m_meta_tvalid && m_meta_tready) begin
            got_meta.push_back(m_meta_tdata);
            got_meta_cyc.push_back(cyc);
         end
         d_stall <= m_data_tvalid && !m_data_tready;
         d_hold  <= {m_data_tlast, m_data_tkeep, m_data_tdata};
         m_stall <= m_meta_tvalid && !m_meta_tready;
         m_hold  <= m_meta_tdata;
      end
   end

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [KEEP_W-1:0] keep_of(input int n);
      logic [KEEP_W-1:0] one;
      one = 1;
      return (n >= KEEP_W) ? '1 : ((one << n) - 1);
   endfunction

   // Build a packet of n beats; only the last beat may have a partial keep.
   task automatic make_packet(input int n, input int last_bytes);
      pkt_q.delete();
      for (int i = 0; i < n; i++)
         pkt_q.push_back('{d: rand_data(), k: keep_of(i == n - 1 ? last_bytes : KEEP_W), l: (i == n - 1)});
   endtask

   // Reference: first min(n, MAX_BEATS) beats pass, the last passed beat is
   // marked last, and one meta word summarises what was passed.
   task automatic model_packet();
      int n, w, len;
      beat_t b;
      n = pkt_q.size();
      w = (n > MAX_BEATS) ? MAX_BEATS : n;
      len = 0;
      for (int i = 0; i < w; i++) begin
         b = pkt_q[i];
         b.l = (i == w - 1);
         len += $countones(b.k);
         exp_data.push_back(b);
      end
      if (len > 65535) len = 65535;
      exp_meta.push_back({(n > MAX_BEATS), 12'(w), 16'(len), pkt_q[0].d[HDR_BYTES*8-1:0]});
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic put_beat(input beat_t b);
      int t;
      logic acc;
      s_tvalid = 1'b1;
      s_tdata  = b.d;
      s_tkeep  = b.k;
      s_tlast  = b.l;
      t = 0;
      forever begin
         acc = s_tready;
         @(negedge clk);
         if (acc) begin
            last_acc = cyc - 1;
            break;
         end
         t++;
         if (t > 3000) begin
            tmo++;
            break;
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic send_packet(input int gap_pct);
      for (int i = 0; i < pkt_q.size(); i++) begin
         while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
         put_beat(pkt_q[i]);
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((got_data.size() < exp_data.size() || got_meta.size() < exp_meta.size()) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) tmo++;
      repeat (5) @(negedge clk);
   endtask

   function automatic int stream_errs();
      int e;
      e = 0;
      if (got_data.size() != exp_data.size()) e++;
      if (got_meta.size() != exp_meta.size()) e++;
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
         if (got_data[i].d !== exp_data[i].d || got_data[i].k !== exp_data[i].k || got_data[i].l !== exp_data[i].l) e++;
      for (int i = 0; i < got_meta.size() && i < exp_meta.size(); i++)
         if (got_meta[i] !== exp_meta[i]) e++;
      return e + tmo;
   endfunction

   task automatic clear_queues();
      got_data.delete(); got_meta.delete(); got_data_cyc.delete(); got_meta_cyc.delete();
      exp_data.delete(); exp_meta.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %0b expected 0", s_tready); end
      checks++; if ({m_data_tvalid, m_data_tlast, m_meta_tvalid, m_meta_tlast} !== 4'b0) begin errors++;
         $display("FAIL reset_valid_last: got %b expected 0000", {m_data_tvalid, m_data_tlast, m_meta_tvalid, m_meta_tlast}); end
      checks++; if ({m_data_tdata, m_data_tkeep} !== '0) begin errors++; $display("FAIL reset_data: got nonzero expected 0"); end
      checks++; if (m_meta_tdata !== '0) begin errors++; $display("FAIL reset_meta: got nonzero expected 0"); end
      rst = 1'b1;
      #1;
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b expected 1", s_tready); end
      @(negedge clk);
   endtask

   task automatic test_three_beat();
      meta_t mt;
      int unsigned a0;
      clear_queues();
      d_rdy_mode = 0; m_rdy_mode = 0;
      @(negedge clk);
      make_packet(3, 16);
      model_packet();
      put_beat(pkt_q[0]);
      a0 = last_acc;
      put_beat(pkt_q[1]);
      put_beat(pkt_q[2]);
      wait_drain();
      mt = got_meta[0];
      checks++; if (stream_errs() !== 0) begin errors++; $display("FAIL three_stream: got %0d errors expected 0", stream_errs()); end
      checks++; if (mt.len !== 16'd144 || mt.beats !== 12'd3 || mt.trunc !== 1'b0) begin errors++;
         $display("FAIL three_meta: got len=%0d beats=%0d trunc=%0b expected 144/3/0", mt.len, mt.beats, mt.trunc); end
      checks++; if (mt.hdr !== pkt_q[0].d[255:0]) begin errors++; $display("FAIL three_hdr: got %h expected %h", mt.hdr, pkt_q[0].d[255:0]); end
      checks++; if (got_data[2].l !== 1'b1 || got_data[1].l !== 1'b0) begin errors++;
         $display("FAIL three_tlast: got %b%b expected 01", got_data[1].l, got_data[2].l); end
      checks++; if (got_data_cyc[0] !== a0 + 2 || got_data_cyc[2] !== a0 + 4) begin errors++;
         $display("FAIL three_latency: got %0d,%0d expected %0d,%0d", got_data_cyc[0], got_data_cyc[2], a0 + 2, a0 + 4); end
      checks++; if (got_meta_cyc[0] !== a0 + 4) begin errors++; $display("FAIL meta_latency: got %0d expected %0d", got_meta_cyc[0], a0 + 4); end
   endtask

   task automatic test_truncation();
      meta_t m0, m1, m2;
      clear_queues();
      make_packet(30, KEEP_W); model_packet(); send_packet(0);
      make_packet(2, 5);       model_packet(); send_packet(0);
      make_packet(24, KEEP_W); model_packet(); send_packet(0);
      wait_drain();
      m0 = got_meta[0]; m1 = got_meta[1]; m2 = got_meta[2];
      checks++; if (stream_errs() !== 0) begin errors++; $display("FAIL trunc_stream: got %0d errors expected 0", stream_errs()); end
      checks++; if (got_data.size() !== 50) begin errors++; $display("FAIL trunc_count: got %0d beats expected 50", got_data.size()); end
      checks++; if (got_data[23].l !== 1'b1) begin errors++; $display("FAIL trunc_tlast: got %0b expected 1", got_data[23].l); end
      checks++; if (m0.trunc !== 1'b1 || m0.beats !== 12'd24 || m0.len !== 16'd1536) begin errors++;
         $display("FAIL trunc_meta: got trunc=%0b beats=%0d len=%0d expected 1/24/1536", m0.trunc, m0.beats, m0.len); end
      checks++; if (m1.trunc !== 1'b0 || m1.beats !== 12'd2 || m1.len !== 16'd69) begin errors++;
         $display("FAIL after_trunc_meta: got trunc=%0b beats=%0d len=%0d expected 0/2/69", m1.trunc, m1.beats, m1.len); end
      checks++; if (m2.trunc !== 1'b0 || m2.beats !== 12'd24) begin errors++;
         $display("FAIL exact_max_meta: got trunc=%0b beats=%0d expected 0/24", m2.trunc, m2.beats); end
   endtask

   task automatic test_data_backpressure();
      int i;
      int hv0;
      logic acc;
      clear_queues();
      hv0 = hold_viol;
      d_rdy_mode = 1;
      @(negedge clk);
      make_packet(20, 40);
      model_packet();
      i = 0;
      while (i < 20) begin
         s_tvalid = 1'b1; s_tdata = pkt_q[i].d; s_tkeep = pkt_q[i].k; s_tlast = pkt_q[i].l;
         acc = s_tready;
         @(negedge clk);
         if (!acc) break;
         i++;
      end
      repeat (3) @(negedge clk);
      checks++; if (i !== 16) begin errors++; $display("FAIL data_fill: got %0d accepted expected 16", i); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL data_full_ready: got %0b expected 0", s_tready); end
      checks++; if (m_data_tvalid !== 1'b1 || m_data_tdata !== pkt_q[0].d) begin errors++;
         $display("FAIL data_held: got valid=%0b expected valid=1 with first beat", m_data_tvalid); end
      checks++; if (hold_viol !== hv0) begin errors++; $display("FAIL data_stable: got %0d changes expected %0d", hold_viol, hv0); end
      d_rdy_mode = 0;
      for (int j = i; j < 20; j++) put_beat(pkt_q[j]);
      wait_drain();
      checks++; if (stream_errs() !== 0) begin errors++; $display("FAIL data_bp_stream: got %0d errors expected 0", stream_errs()); end
   endtask

   task automatic test_meta_backpressure();
      int p;
      logic acc;
      clear_queues();
      m_rdy_mode = 1;
      @(negedge clk);
      p = 0;
      while (p < 8) begin
         make_packet(1, $urandom_range(1, KEEP_W));
         model_packet();
         s_tvalid = 1'b1; s_tdata = pkt_q[0].d; s_tkeep = pkt_q[0].k; s_tlast = 1'b1;
         acc = s_tready;
         @(negedge clk);
         if (!acc) break;
         p++;
      end
      repeat (3) @(negedge clk);
      checks++; if (p !== 4) begin errors++; $display("FAIL meta_fill: got %0d packets expected 4", p); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL meta_full_ready: got %0b expected 0", s_tready); end
      checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL data_drain_during_meta_stall: got %0d expected 4", got_data.size()); end
      checks++; if (m_meta_tvalid !== 1'b1 || m_meta_tlast !== 1'b1) begin errors++;
         $display("FAIL meta_held: got valid=%0b last=%0b expected 1/1", m_meta_tvalid, m_meta_tlast); end
      m_rdy_mode = 0;
      put_beat(pkt_q[0]);
      wait_drain();
      checks++; if (stream_errs() !== 0) begin errors++; $display("FAIL meta_bp_stream: got %0d errors expected 0", stream_errs()); end
   endtask

   task automatic test_reset_mid_packet();
      meta_t mt;
      clear_queues();
      d_rdy_mode = 1;
      @(negedge clk);
      make_packet(5, KEEP_W);
      put_beat(pkt_q[0]);
      put_beat(pkt_q[1]);
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({s_tready, m_data_tvalid, m_meta_tvalid, m_data_tlast} !== 4'b0) begin errors++;
         $display("FAIL mid_reset_flags: got %b expected 0000", {s_tready, m_data_tvalid, m_meta_tvalid, m_data_tlast}); end
      checks++; if ({m_data_tdata, m_data_tkeep} !== '0) begin errors++; $display("FAIL mid_reset_data: got nonzero expected 0"); end
      rst = 1'b1;
      d_rdy_mode = 0;
      clear_queues();
      repeat (4) @(negedge clk);
      checks++; if (got_data.size() !== 0) begin errors++; $display("FAIL mid_reset_empty: got %0d beats expected 0", got_data.size()); end
      make_packet(1, 7);
      model_packet();
      send_packet(0);
      wait_drain();
      mt = got_meta[0];
      checks++; if (mt.beats !== 12'd1 || mt.trunc !== 1'b0 || mt.len !== 16'd7) begin errors++;
         $display("FAIL mid_reset_meta: got beats=%0d trunc=%0b len=%0d expected 1/0/7", mt.beats, mt.trunc, mt.len); end
      checks++; if (stream_errs() !== 0) begin errors++; $display("FAIL mid_reset_stream: got %0d errors expected 0", stream_errs()); end
   endtask

   task automatic test_random();
      clear_queues();
      d_rdy_mode = 2; m_rdy_mode = 2;
      for (int p = 0; p < 1000; p++) begin
         make_packet($urandom_range(1, 40), $urandom_range(1, KEEP_W));
         model_packet();
         send_packet(15);
      end
      wait_drain();
      checks++; if (stream_errs() !== 0) begin errors++;
         $display("FAIL random_stream: got %0d errors (data %0d/%0d meta %0d/%0d) expected 0",
                  stream_errs(), got_data.size(), exp_data.size(), got_meta.size(), exp_meta.size()); end
      checks++; if (hold_viol !== 0) begin errors++; $display("FAIL random_hold: got %0d changes expected 0", hold_viol); end
   endtask

   initial begin
      rst = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      @(negedge clk);
      test_reset();
      test_three_beat();
      test_truncation();
      test_data_backpressure();
      test_meta_backpressure();
      test_reset_mid_packet();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_meta_splitter.md
# axis_meta_splitter

Parametrised successor to the single-width stream splitter. Accepts one AXI4-Stream ingress packet stream and fans it into two independently back-pressured egress streams: a data stream carrying every accepted beat through an internal delay FIFO, and a one-beat-per-packet metadata stream carrying byte length, beat count, truncation flag and captured header bytes. It sits between the ingress MAC-side stream and the classifier/payload buffers. Unlike the previous generation, it adds TKEEP-accurate length counting, a metadata FIFO, truncation of over-length packets, and AXI-compliant held TVALID on both outputs.

## Interface
- DATA_W, 512, ingress/data-egress TDATA width in bits; multiple of 8
- DATA_DEPTH, 16, data FIFO entries; power of 2, ≥4
- META_DEPTH, 4, metadata FIFO entries; power of 2, ≥2
- HDR_BYTES, 32, header bytes captured from the first beat; ≤ DATA_W/8
- MAX_BEATS, 24, maximum beats per packet before truncation; ≤ 4095
- Derived: KEEP_W = DATA_W/8; META_W = HDR_BYTES*8 + 16 + 12 + 1
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low
- s_tvalid / s_tready  in / out  1 / 1  ingress handshake
- s_tdata  in  DATA_W  ingress data
- s_tkeep  in  KEEP_W  byte enables; contiguous from bit 0
- s_tlast  in  1  end of packet
- m_data_tvalid / m_data_tready  out / in  1 / 1  data egress handshake
- m_data_tdata  out  DATA_W;  m_data_tkeep  out  KEEP_W;  m_data_tlast  out  1
- m_meta_tvalid / m_meta_tready  out / in  1 / 1  metadata egress handshake
- m_meta_tdata  out  META_W  {trunc, beats[11:0], len[15:0], hdr[HDR_BYTES*8-1:0]} MSB→LSB
- m_meta_tlast  out  1  constant 1 whenever m_meta_tvalid

## Operation
- Accept = s_tvalid && s_tready. s_tready = rst high && !data_full && !meta_full (combinational from FIFO flags only; never from s_tvalid).
- FSM states: SOP, BODY, DROP. Reset → SOP.
  - SOP, accept: capture s_tdata[HDR_BYTES*8-1:0] into hdr; beats←1; len←popcount(s_tkeep); write beat to data FIFO. If s_tlast → write meta, stay SOP; else → BODY.
  - BODY, accept: beats+1, len += popcount(s_tkeep) (saturate at 0xFFFF); write beat. If s_tlast → write meta, → SOP. Else if new beats == MAX_BEATS → write beat with tlast forced 1, write meta with trunc=1, → DROP.
  - DROP, accept: beat discarded (not written); on s_tlast → SOP. No meta.
- MAX_BEATS==1: SOP beat without tlast truncates immediately → DROP.
- Meta write for a packet occurs on the same cycle as its last data-FIFO write; ordering between streams is preserved packet-for-packet.
- Both egress outputs are registered skid stages fed from their FIFOs: once TVALID rises it holds, with TDATA/TKEEP/TLAST stable, until TREADY. Refill on the transfer cycle gives one beat per cycle under continuous ready.
- Data and meta egress are independent; stall on one only stalls ingress via its FIFO filling.

## Timing
- Reset (rst low at a clock edge): all outputs 0 the following cycle (s_tready, both TVALIDs, all TDATA/TKEEP/TLAST); FIFOs emptied, counters 0, FSM SOP. Reset mid-packet discards the partial packet; the next accepted beat is SOP.
- Latency: beat accepted at edge N appears on m_data at N+1 (empty FIFO, output idle). Meta for packet ending at edge N valid at N+1.
- Throughput: 1 beat/cycle sustained with both readies high.
- FIFO full: s_tready low same cycle full asserts; a simultaneous read and write while full is not taken (s_tready already low). Simultaneous read and write at empty: write passes through on next cycle.
- Pointer wrap: log2(DEPTH)+1-bit pointers; full/empty from MSB compare; no lost or duplicated entries across wrap.
- len saturates at 0xFFFF; beats never exceeds MAX_BEATS.

## Structure
- Package axis_split_pkg: meta_t packed struct (trunc, beats, len, hdr — hdr width fixed by package parameter matching HDR_BYTES default), state enum {SOP, BODY, DROP}, popcount function for TKEEP.
- One sub-module sync_fifo (params WIDTH, DEPTH; sync active-low reset; wr_en/rd_en/full/empty), instantiated twice: data (DATA_W+KEEP_W+1) and meta (META_W).
- Output skid registers and FSM in top level.

## Test plan
- Single 3-beat packet, keep all-ones, last beat keep=0x0000_0000_0000_FFFF, both readies 1 → 3 data beats at N+1..N+3, tlast on third; one meta len=144, beats=3, trunc=0, hdr = first beat low 32 bytes.
- 30-beat packet, MAX_BEATS=24 → 24 data beats, 24th tlast=1; meta beats=24, len=1536, trunc=1; beats 25–30 accepted and dropped; next packet parses normally.
- m_data_tready held 0 → after 16 accepted beats s_tready=0; TVALID/TDATA on m_data stable throughout; release → all 16 drain in order, none lost.
- m_meta_tready 0, stream of 1-beat packets → s_tready drops after 4 packets; data egress continues draining; release → 4 metas in order.
- rst low mid-packet (beat 2 of 5) → outputs 0 next cycle, FIFOs empty; subsequent 1-beat packet yields meta beats=1, trunc=0.
- Random valid/ready, 1000 packets of 1–40 beats → scoreboard matches data and meta streams exactly, including pointer wrap.
